// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c register-transaction sequencer:
// engine command encodings, address LSB constants, FSM state enums
// and the byte-list helper functions.
package i2c_pkg;

  // Engine command encoding: {stop, write, go}
  localparam logic [2:0] CMD_NONE    = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b011;
  localparam logic [2:0] CMD_WR_STOP = 3'b111;
  localparam logic [2:0] CMD_RD_STOP = 3'b101;

  // LSB appended to the 7-bit device address
  localparam logic ADDR_WR_LSB = 1'b0;
  localparam logic ADDR_RD_LSB = 1'b1;

  // Byte sent with a stop to release the bus after a NACK
  localparam logic [7:0] ABORT_BYTE = 8'hFF;
  // DATA_IN during the read-data byte: keep SDA released
  localparam logic [7:0] RD_FILL    = 8'hFF;

  // Per-byte handshake FSM (i2c_byte_step)
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_CHECK   = 3'd4
  } step_state_t;

  // Transaction-level FSM (i2c_reg_seq)
  typedef enum logic [1:0] {
    SQ_IDLE  = 2'd0,
    SQ_BYTE  = 2'd1,
    SQ_ABORT = 2'd2
  } seq_state_t;

  // Decision taken when a byte finishes
  typedef enum logic [2:0] {
    OUT_NONE    = 3'd0,
    OUT_NEXT    = 3'd1,
    OUT_ABORT   = 3'd2,
    OUT_OK      = 3'd3,
    OUT_RDATA   = 3'd4,
    OUT_NACK    = 3'd5,
    OUT_TIMEOUT = 3'd6
  } outcome_t;

  // Command for byte idx of a write (3 bytes) or read (4 bytes)
  function automatic logic [2:0] seq_cmd(input logic rd, input logic [1:0] idx);
    case (idx)
      2'd0:    seq_cmd = CMD_WR;
      2'd1:    seq_cmd = rd ? CMD_WR_STOP : CMD_WR;
      2'd2:    seq_cmd = rd ? CMD_WR : CMD_WR_STOP;
      default: seq_cmd = CMD_RD_STOP;
    endcase
  endfunction

  // DATA_IN for byte idx; a read uses two frames since the engine has no repeated start
  function automatic logic [7:0] seq_din(input logic rd, input logic [1:0] idx,
                                         input logic [6:0] dev, input logic [7:0] rg,
                                         input logic [7:0] wd);
    case (idx)
      2'd0:    seq_din = {dev, ADDR_WR_LSB};
      2'd1:    seq_din = rg;
      2'd2:    seq_din = rd ? {dev, ADDR_RD_LSB} : wd;
      default: seq_din = RD_FILL;
    endcase
  endfunction

  // True for the final byte of the list
  function automatic logic seq_last(input logic rd, input logic [1:0] idx);
    seq_last = rd ? (idx == 2'd3) : (idx == 2'd2);
  endfunction

endpackage

// File: rtl/i2c_byte_step.sv
// One engine byte: pulse COMMAND for one cycle, wait for BUSY to rise
// (bounded by BUSY_TO) and fall, then report ERROR/DATA_OUT for one
// cycle in ST_CHECK (o_done=1).
// i_start is honoured only in ST_IDLE.
module i2c_byte_step
  import i2c_pkg::*;
#(
  parameter int BUSY_TO = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_cmd,
  input  logic [7:0]  i_din,
  input  logic        i_busy,
  input  logic        i_error,
  input  logic [7:0]  i_dout,
  output logic [2:0]  o_cmd,
  output logic [7:0]  o_din,
  output logic        o_done,
  output logic        o_timeout,
  output logic        o_error,
  output logic [7:0]  o_dout,
  output step_state_t o_state
);

  localparam int CNT_W = $clog2(BUSY_TO + 1);
  // Last WAIT_HI count; the CHECK cycle completes the BUSY_TO window
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TO - 2);

  step_state_t      r_state;
  logic [2:0]       r_cmd;
  logic [7:0]       r_din;
  logic [CNT_W-1:0] r_cnt;
  logic             r_to;
  logic             r_err;
  logic [7:0]       r_dout;

  // Byte handshake FSM with registered engine command/data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cmd   <= CMD_NONE;
      r_din   <= 8'h00;
      r_cnt   <= '0;
      r_to    <= 1'b0;
      r_err   <= 1'b0;
      r_dout  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_cmd   <= i_cmd;
            r_din   <= i_din;
            r_to    <= 1'b0;
            r_err   <= 1'b0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cmd   <= CMD_NONE;
          r_cnt   <= '0;
          r_state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (i_busy) begin
            r_state <= ST_WAIT_LO;
          end else if (r_cnt == CNT_LAST) begin
            r_to    <= 1'b1;
            r_state <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!i_busy) begin
            r_err   <= i_error;
            r_dout  <= i_dout;
            r_state <= ST_CHECK;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd     = r_cmd;
  assign o_din     = r_din;
  assign o_done    = (r_state == ST_CHECK);
  assign o_timeout = r_to;
  assign o_error   = r_err;
  assign o_dout    = r_dout;
  assign o_state   = r_state;

endmodule

// File: rtl/i2c_reg_seq.sv
// Register write/read sequencer in front of the byte-level i2c engine.
// Walks the byte list, aborts with a stop byte after an address/reg
// NACK, and reports RDATA/NACK/TIMEOUT with a one-cycle DONE.
// Optional build macro I2C_RETRY_EN: restart a NACKed transaction up
// to MAX_RETRY times.
//
// Host handshake: i_req is sampled only at a posedge where o_ready=1;
// that edge latches the request and drops o_ready. o_done pulses one
// cycle with o_ready=1 in the same cycle, so a request held in the DONE
// cycle is accepted. i_req while o_ready=0 is ignored.
module i2c_reg_seq
  import i2c_pkg::*;
#(
  parameter int BUSY_TO = 8
`ifdef I2C_RETRY_EN
  ,
  parameter int MAX_RETRY = 2
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_req_rd,
  input  logic [6:0]  i_req_dev,
  input  logic [7:0]  i_req_reg,
  input  logic [7:0]  i_req_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic [7:0]  o_rdata,
  output logic        o_nack,
  output logic        o_timeout,
  output logic [2:0]  o_i2c_cmd,
  output logic [7:0]  o_i2c_din,
  input  logic        i_i2c_busy,
  input  logic        i_i2c_error,
  input  logic [7:0]  i_i2c_dout,
  output seq_state_t  o_dbg_seq,
  output step_state_t o_dbg_step
);

  seq_state_t r_state;
  logic       r_ready;
  logic       r_done;
  logic [7:0] r_rdata;
  logic       r_nack;
  logic       r_timeout;
  logic       r_rd;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [7:0] r_wdata;
  logic [1:0] r_idx;
  logic       r_start;
  logic [2:0] r_bcmd;
  logic [7:0] r_bdin;
`ifdef I2C_RETRY_EN
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);
  logic [1:0] r_retry;
`endif

  logic       w_step_done;
  logic       w_step_to;
  logic       w_step_err;
  logic [7:0] w_step_dout;
  logic [1:0] w_idx_nxt;
  outcome_t   w_out;

  i2c_byte_step #(
    .BUSY_TO (BUSY_TO)
  ) u_step (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (r_start),
    .i_cmd     (r_bcmd),
    .i_din     (r_bdin),
    .i_busy    (i_i2c_busy),
    .i_error   (i_i2c_error),
    .i_dout    (i_i2c_dout),
    .o_cmd     (o_i2c_cmd),
    .o_din     (o_i2c_din),
    .o_done    (w_step_done),
    .o_timeout (w_step_to),
    .o_error   (w_step_err),
    .o_dout    (w_step_dout),
    .o_state   (o_dbg_step)
  );

  assign w_idx_nxt = r_idx + 2'd1;

  // Classify the byte that just finished; ERROR is ignored on the read-data byte
  always_comb begin
    w_out = OUT_NONE;
    if (w_step_done) begin
      case (r_state)
        SQ_BYTE: begin
          if (w_step_to)                   w_out = OUT_TIMEOUT;
          else if (r_rd && r_idx == 2'd3)  w_out = OUT_RDATA;
          else if (w_step_err)             w_out = r_bcmd[2] ? OUT_NACK : OUT_ABORT;
          else if (seq_last(r_rd, r_idx))  w_out = OUT_OK;
          else                             w_out = OUT_NEXT;
        end
        SQ_ABORT: begin
          w_out = w_step_to ? OUT_TIMEOUT : OUT_NACK;
        end
        default: w_out = OUT_NONE;
      endcase
    end
  end

  // Transaction FSM: request latch, byte launch, abort, retry and finish
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= SQ_IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_rdata   <= 8'h00;
      r_nack    <= 1'b0;
      r_timeout <= 1'b0;
      r_rd      <= 1'b0;
      r_dev     <= 7'h00;
      r_reg     <= 8'h00;
      r_wdata   <= 8'h00;
      r_idx     <= 2'd0;
      r_start   <= 1'b0;
      r_bcmd    <= CMD_NONE;
      r_bdin    <= 8'h00;
`ifdef I2C_RETRY_EN
      r_retry   <= 2'd0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_start <= 1'b0;
      if (r_state == SQ_IDLE) begin
        if (i_req) begin
          r_rd      <= i_req_rd;
          r_dev     <= i_req_dev;
          r_reg     <= i_req_reg;
          r_wdata   <= i_req_wdata;
          r_nack    <= 1'b0;
          r_timeout <= 1'b0;
          r_ready   <= 1'b0;
          r_idx     <= 2'd0;
          r_start   <= 1'b1;
          r_bcmd    <= seq_cmd(i_req_rd, 2'd0);
          r_bdin    <= seq_din(i_req_rd, 2'd0, i_req_dev, i_req_reg, i_req_wdata);
          r_state   <= SQ_BYTE;
`ifdef I2C_RETRY_EN
          r_retry   <= 2'd0;
`endif
        end
      end else begin
        case (w_out)
          OUT_NEXT: begin
            r_idx   <= w_idx_nxt;
            r_start <= 1'b1;
            r_bcmd  <= seq_cmd(r_rd, w_idx_nxt);
            r_bdin  <= seq_din(r_rd, w_idx_nxt, r_dev, r_reg, r_wdata);
          end
          OUT_ABORT: begin
            r_start <= 1'b1;
            r_bcmd  <= CMD_WR_STOP;
            r_bdin  <= ABORT_BYTE;
            r_state <= SQ_ABORT;
          end
          OUT_OK: begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= SQ_IDLE;
          end
          OUT_RDATA: begin
            r_rdata <= w_step_dout;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= SQ_IDLE;
          end
          OUT_TIMEOUT: begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= SQ_IDLE;
          end
          OUT_NACK: begin
`ifdef I2C_RETRY_EN
            if (r_retry < RETRY_LIM) begin
              r_retry <= r_retry + 2'd1;
              r_idx   <= 2'd0;
              r_start <= 1'b1;
              r_bcmd  <= seq_cmd(r_rd, 2'd0);
              r_bdin  <= seq_din(r_rd, 2'd0, r_dev, r_reg, r_wdata);
              r_state <= SQ_BYTE;
            end else begin
              r_nack  <= 1'b1;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_state <= SQ_IDLE;
            end
`else
            r_nack  <= 1'b1;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= SQ_IDLE;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign o_ready   = r_ready;
  assign o_done    = r_done;
  assign o_rdata   = r_rdata;
  assign o_nack    = r_nack;
  assign o_timeout = r_timeout;
  assign o_dbg_seq = r_state;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq with a behavioural byte-engine model.
// Honours I2C_RETRY_EN when the build defines it.
module tb_i2c_reg_seq;
  import i2c_pkg::*;

  localparam int BUSY_TO = 8;
`ifdef I2C_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic        req = 1'b0, req_rd = 1'b0;
  logic [6:0]  req_dev = 7'h00;
  logic [7:0]  req_reg = 8'h00, req_wdata = 8'h00;
  logic        ready, done, nack, timeout;
  logic [7:0]  rdata, i2c_din;
  logic [2:0]  i2c_cmd;
  logic        busy = 1'b0, error = 1'b0;
  logic [7:0]  dout = 8'h00;
  seq_state_t  dbg_seq;
  step_state_t dbg_step;

  i2c_reg_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_req_rd    (req_rd),
    .i_req_dev   (req_dev),
    .i_req_reg   (req_reg),
    .i_req_wdata (req_wdata),
    .o_ready     (ready),
    .o_done      (done),
    .o_rdata     (rdata),
    .o_nack      (nack),
    .o_timeout   (timeout),
    .o_i2c_cmd   (i2c_cmd),
    .o_i2c_din   (i2c_din),
    .i_i2c_busy  (busy),
    .i_i2c_error (error),
    .i_i2c_dout  (dout),
    .o_dbg_seq   (dbg_seq),
    .o_dbg_step  (dbg_step)
  );

  // ---------------- engine model ----------------
  logic        eng_rst = 1'b1;
  logic        no_busy = 1'b0;
  logic [7:0]  rd_val = 8'h00;
  logic [2:0]  nack_cmd = 3'b000;
  logic [7:0]  nack_din = 8'h00;
  int          nack_n = 0;
  int          bcnt = 0;
  int          issue_cyc = 0;
  int          done_cnt = 0;
  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];

  always @(negedge clk) begin
    if (eng_rst) begin
      busy = 1'b0;
      bcnt = 0;
    end else if (bcnt != 0) begin
      bcnt--;
      if (bcnt == 0) busy = 1'b0;
    end else if (i2c_cmd[0]) begin
      obs_q.push_back({i2c_cmd, i2c_din});
      issue_cyc = cyc;
      if (!no_busy) begin
        busy  = 1'b1;
        bcnt  = 3;
        error = 1'b0;
        if (i2c_cmd == 3'b101) begin
          error = 1'b1;
          dout  = rd_val;
        end else if (i2c_cmd == 3'b111 && i2c_din == 8'hFF) begin
          error = 1'b1;
        end else if (nack_n != 0 && i2c_cmd == nack_cmd && i2c_din == nack_din) begin
          error = 1'b1;
          nack_n--;
        end
      end
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [7:0] d);
    exp_q.push_back({c, d});
  endtask

  task automatic check_log(input string tag);
    int n;
    check($sformatf("%s_bytes", tag), obs_q.size(), exp_q.size());
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check($sformatf("%s_byte%0d", tag, n), obs_q.pop_front(), exp_q.pop_front());
      n++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_ready", tag), ready, 1);
    check($sformatf("%s_done", tag), done, 0);
    check($sformatf("%s_rdata", tag), rdata, 0);
    check($sformatf("%s_nack", tag), nack, 0);
    check($sformatf("%s_timeout", tag), timeout, 0);
    check($sformatf("%s_cmd", tag), i2c_cmd, 0);
    check($sformatf("%s_din", tag), i2c_din, 0);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; request is sampled at the next posedge
  task automatic start_req(input logic rd, input logic [6:0] dv, input logic [7:0] rg,
                           input logic [7:0] wd);
    req = 1'b1; req_rd = rd; req_dev = dv; req_reg = rg; req_wdata = wd;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check($sformatf("%s_done_seen", tag), done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    eng_rst = 1'b0;
    @(negedge clk);

    // Plain write
    done_cnt = 0;
    push(3'b011, 8'h78); push(3'b011, 8'h12); push(3'b111, 8'hA5);
    start_req(1'b0, 7'h3C, 8'h12, 8'hA5);
    check("wr_accept", ready, 0);
    wait_done("wr");
    check("wr_ready", ready, 1);
    check("wr_nack", nack, 0);
    check("wr_timeout", timeout, 0);
    @(negedge clk);
    check("wr_done_pulse", done, 0);
    repeat (2) @(negedge clk);
    check("wr_done_cnt", done_cnt, 1);
    check_log("wr");

    // Read, with a REQ while busy that must be ignored
    done_cnt = 0;
    rd_val = 8'h5A;
    push(3'b011, 8'h78); push(3'b111, 8'h05); push(3'b011, 8'h79); push(3'b101, 8'hFF);
    start_req(1'b1, 7'h3C, 8'h05, 8'h00);
    check("rd_accept", ready, 0);
    repeat (4) @(negedge clk);
    start_req(1'b0, 7'h11, 8'h99, 8'h44);
    wait_done("rd");
    check("rd_rdata", rdata, 8'h5A);
    check("rd_nack", nack, 0);
    check("rd_timeout", timeout, 0);
    repeat (3) @(negedge clk);
    check("rd_done_cnt", done_cnt, 1);
    check_log("rd");

    // Write, address NACKed -> abort byte
    nack_cmd = 3'b011; nack_din = 8'h78; nack_n = 100;
    for (int a = 0; a < ATTEMPTS; a++) begin
      push(3'b011, 8'h78); push(3'b111, 8'hFF);
    end
    start_req(1'b0, 7'h3C, 8'h12, 8'hA5);
    wait_done("wna");
    check("wna_nack", nack, 1);
    check("wna_timeout", timeout, 0);
    check("wna_rdata", rdata, 8'h5A);
    nack_n = 0;
    @(negedge clk);
    check_log("wna");

    // Read, reg byte (with stop) NACKed -> no abort
    rd_val = 8'h66;
    nack_cmd = 3'b111; nack_din = 8'h05; nack_n = 100;
    for (int a = 0; a < ATTEMPTS; a++) begin
      push(3'b011, 8'h78); push(3'b111, 8'h05);
    end
    start_req(1'b1, 7'h3C, 8'h05, 8'h00);
    wait_done("rnr");
    check("rnr_nack", nack, 1);
    check("rnr_rdata", rdata, 8'h5A);
    nack_n = 0;
    @(negedge clk);
    check_log("rnr");

    // Read, second-frame address NACKed -> abort byte, RDATA held
    nack_cmd = 3'b011; nack_din = 8'h79; nack_n = 100;
    for (int a = 0; a < ATTEMPTS; a++) begin
      push(3'b011, 8'h78); push(3'b111, 8'h05); push(3'b011, 8'h79); push(3'b111, 8'hFF);
    end
    start_req(1'b1, 7'h3C, 8'h05, 8'h00);
    wait_done("rna");
    check("rna_nack", nack, 1);
    check("rna_rdata", rdata, 8'h5A);
    nack_n = 0;
    @(negedge clk);
    check_log("rna");

    // Engine never goes busy -> TIMEOUT, DONE BUSY_TO+1 cycles after ISSUE
    no_busy = 1'b1;
    push(3'b011, 8'h78);
    start_req(1'b0, 7'h3C, 8'h12, 8'hA5);
    wait_done("to");
    check("to_latency", cyc - issue_cyc, BUSY_TO + 1);
    check("to_timeout", timeout, 1);
    check("to_nack", nack, 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("to_cmd_idle%0d", k), i2c_cmd, 0);
      @(negedge clk);
    end
    no_busy = 1'b0;
    check_log("to");

    // Reset during WAIT_LO of the second byte
    start_req(1'b0, 7'h3C, 8'h12, 8'hA5);
    for (int i = 0; i < 200; i++) begin
      if (obs_q.size() == 2 && dbg_step == ST_WAIT_LO) break;
      @(negedge clk);
    end
    check("mid_wait_lo_seen", dbg_step, ST_WAIT_LO);
    rst_n = 1'b0;
    eng_rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    eng_rst = 1'b0;
    obs_q.delete();
    @(negedge clk);
    push(3'b011, 8'hA2); push(3'b011, 8'h22); push(3'b111, 8'h33);
    start_req(1'b0, 7'h51, 8'h22, 8'h33);
    wait_done("post");
    check("post_nack", nack, 0);
    check_log("post");

    // Back-to-back: REQ in the DONE cycle is accepted
    rd_val = 8'hC3;
    push(3'b011, 8'hA2); push(3'b111, 8'h40); push(3'b011, 8'hA3); push(3'b101, 8'hFF);
    start_req(1'b1, 7'h51, 8'h40, 8'h00);
    check("b2b_accept", ready, 0);
    wait_done("b2b");
    check("b2b_rdata", rdata, 8'hC3);
    check("b2b_nack", nack, 0);
    @(negedge clk);
    check_log("b2b");

`ifdef I2C_RETRY_EN
    // Two NACKed attempts, third succeeds
    nack_cmd = 3'b011; nack_din = 8'h78; nack_n = 2;
    push(3'b011, 8'h78); push(3'b111, 8'hFF);
    push(3'b011, 8'h78); push(3'b111, 8'hFF);
    push(3'b011, 8'h78); push(3'b011, 8'h12); push(3'b111, 8'hA5);
    start_req(1'b0, 7'h3C, 8'h12, 8'hA5);
    wait_done("rty");
    check("rty_nack", nack, 0);
    check("rty_timeout", timeout, 0);
    @(negedge clk);
    check_log("rty");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
